relin_stream_engine: RTL and testbench

- Parametrised, synthesizable BFV relinearization engine.
- Streams in the degree-2 ciphertext component c2 as tiles and base-2^LOG_T decomposes it.
- Computes the negacyclic products of the digits with the relin key polys, modulo Q, using one MAC per cycle per output lane. Key polys come from an external key memory read port.
- Streams out the c0 and c1 contributions with valid/ready backpressure. Supports multiple key sets, e.g. relin and rotation keys.

---
 rtl/relin_stream_engine.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_relin_stream_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/relin_stream_engine.sv
// BFV relinearization engine: base-2^LOG_T decomposition of streamed c2 tiles,
// negacyclic MACs against external key polys, and c0/c1 tiles streamed back out.
module relin_stream_engine #(
  parameter int DEGREE_N   = 8,
  parameter int TILE_N     = 2,
  parameter int BIT_WIDTH  = 8,
  parameter int Q          = 97,
  parameter int LOG_T      = 2,
  parameter int NUM_DIGITS = 4,
  parameter int NUM_KEYS   = 2,
  parameter int KEY_AW     = $clog2(NUM_KEYS*NUM_DIGITS*DEGREE_N),
  parameter int KSEL_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [TILE_N*BIT_WIDTH-1:0]   coeff_i,
  input  logic [KSEL_W-1:0]             key_sel_i,
  output logic [KEY_AW-1:0]             key_addr_o,
  input  logic [BIT_WIDTH-1:0]          key_rdata0_i,
  input  logic [BIT_WIDTH-1:0]          key_rdata1_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          poly_sel_o,
  output logic                          last_o,
  output logic [TILE_N*BIT_WIDTH-1:0]   coeff_o,
  output logic                          busy_o
);
  localparam int NB  = DEGREE_N / TILE_N;
  localparam int AW  = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;
  localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BTW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW  = LOG_T + BIT_WIDTH;
  localparam int XW  = LOG_T * NUM_DIGITS;
  localparam logic [PW-1:0]        Q_P = PW'(Q);
  localparam logic [BIT_WIDTH:0]   Q_S = (BIT_WIDTH+1)'(Q);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_OUT0, S_OUT1} state_t;

  // One accumulate step; neg selects subtraction for the x^N = -1 wrap.
  function automatic logic [BIT_WIDTH-1:0] mac_step(input logic [BIT_WIDTH-1:0] acc,
                                                    input logic [LOG_T-1:0] d,
                                                    input logic [BIT_WIDTH-1:0] key,
                                                    input logic neg);
    logic [PW-1:0]      prod;
    logic [PW-1:0]      pm;
    logic [BIT_WIDTH:0] addend;
    logic [BIT_WIDTH:0] sum;
    prod   = PW'(d) * PW'(key);
    pm     = prod % Q_P;
    addend = neg ? (Q_S - pm[BIT_WIDTH:0]) : pm[BIT_WIDTH:0];
    sum    = {1'b0, acc} + addend;
    mac_step = (sum >= Q_S) ? BIT_WIDTH'(sum - Q_S) : BIT_WIDTH'(sum);
  endfunction

  function automatic logic [LOG_T-1:0] digit_of(input logic [BIT_WIDTH-1:0] c,
                                                input logic [DW-1:0] i);
    logic [XW-1:0] ext;
    ext = XW'(c);
    digit_of = ext[int'(i)*LOG_T +: LOG_T];
  endfunction

  function automatic logic [KEY_AW-1:0] key_addr_of(input logic [KSEL_W-1:0] s,
                                                    input logic [DW-1:0] i,
                                                    input logic [AW-1:0] b);
    key_addr_of = KEY_AW'((int'(s)*NUM_DIGITS + int'(i))*DEGREE_N + int'(b));
  endfunction

  state_t                        state_q, state_d;
  logic [KSEL_W-1:0]             ksel_q, ksel_d;
  logic [BTW-1:0]                beat_q, beat_d;
  logic                          cur_v_q, cur_v_d, p_v_q, p_v_d;
  logic [DW-1:0]                 cur_i_q, cur_i_d, p_i_q, p_i_d;
  logic [AW-1:0]                 cur_a_q, cur_a_d, p_a_q, p_a_d;
  logic [AW-1:0]                 cur_b_q, cur_b_d, p_b_q, p_b_d;
  logic [KEY_AW-1:0]             key_addr_q, key_addr_d;
  logic                          ready_q, ready_d, valid_q, valid_d;
  logic                          poly_q, poly_d, last_q, last_d, busy_q, busy_d;
  logic [TILE_N*BIT_WIDTH-1:0]   coeff_q, coeff_d;
  logic [BIT_WIDTH-1:0]          c2_q [DEGREE_N];
  logic [BIT_WIDTH-1:0]          c2_d [DEGREE_N];
  logic [BIT_WIDTH-1:0]          acc0_q [DEGREE_N];
  logic [BIT_WIDTH-1:0]          acc0_d [DEGREE_N];
  logic [BIT_WIDTH-1:0]          acc1_q [DEGREE_N];
  logic [BIT_WIDTH-1:0]          acc1_d [DEGREE_N];
  logic                          in_hs_s, out_hs_s, go_mac_s, neg_s;
  logic [AW:0]                   sum_s;
  logic [AW-1:0]                 k_s;
  logic [LOG_T-1:0]              dig_s;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d    = state_q;
    ksel_d     = ksel_q;
    beat_d     = beat_q;
    cur_v_d    = 1'b0;
    cur_i_d    = cur_i_q;
    cur_a_d    = cur_a_q;
    cur_b_d    = cur_b_q;
    p_v_d      = 1'b0;
    p_i_d      = p_i_q;
    p_a_d      = p_a_q;
    p_b_d      = p_b_q;
    key_addr_d = key_addr_q;
    c2_d       = c2_q;
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    go_mac_s   = 1'b0;
    sum_s      = '0;
    k_s        = '0;
    neg_s      = 1'b0;
    dig_s      = '0;
    in_hs_s    = valid_i && ready_q;
    out_hs_s   = valid_q && ready_i;
    case (state_q)
      S_IDLE: begin
        if (in_hs_s) begin
          ksel_d = key_sel_i;
          for (int t = 0; t < TILE_N; t++) c2_d[t] = coeff_i[t*BIT_WIDTH +: BIT_WIDTH];
          for (int k = 0; k < DEGREE_N; k++) begin
            acc0_d[k] = '0;
            acc1_d[k] = '0;
          end
          if (NB == 1) begin
            go_mac_s = 1'b1;
          end else begin
            state_d = S_LOAD;
            beat_d  = BTW'(1);
          end
        end else begin
          beat_d = '0;
        end
      end
      S_LOAD: begin
        if (in_hs_s) begin
          for (int t = 0; t < TILE_N; t++)
            c2_d[AW'(int'(beat_q)*TILE_N + t)] = coeff_i[t*BIT_WIDTH +: BIT_WIDTH];
          if (beat_q == BTW'(NB-1)) go_mac_s = 1'b1;
          else                      beat_d = beat_q + BTW'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      S_MAC: begin
        // The step whose address is on key_addr_o now becomes the step whose data arrives next.
        p_v_d = cur_v_q;
        p_i_d = cur_i_q;
        p_a_d = cur_a_q;
        p_b_d = cur_b_q;
        if (cur_v_q) begin
          cur_v_d = 1'b1;
          if (cur_b_q != AW'(DEGREE_N-1)) begin
            cur_b_d = cur_b_q + AW'(1);
          end else begin
            cur_b_d = '0;
            if (cur_a_q != AW'(DEGREE_N-1)) begin
              cur_a_d = cur_a_q + AW'(1);
            end else begin
              cur_a_d = '0;
              if (cur_i_q != DW'(NUM_DIGITS-1)) begin
                cur_i_d = cur_i_q + DW'(1);
              end else begin
                cur_i_d = '0;
                cur_v_d = 1'b0;
              end
            end
          end
          key_addr_d = key_addr_of(ksel_q, cur_i_d, cur_b_d);
        end else begin
          cur_v_d = 1'b0;
        end
        if (p_v_q) begin
          sum_s = {1'b0, p_a_q} + {1'b0, p_b_q};
          k_s   = sum_s[AW-1:0];
          neg_s = sum_s[AW];
          dig_s = digit_of(c2_q[p_a_q], p_i_q);
          acc0_d[k_s] = mac_step(acc0_q[k_s], dig_s, key_rdata0_i, neg_s);
          acc1_d[k_s] = mac_step(acc1_q[k_s], dig_s, key_rdata1_i, neg_s);
          if (!cur_v_q) begin
            state_d = S_OUT0;
            beat_d  = '0;
          end else begin
            state_d = S_MAC;
          end
        end else begin
          state_d = S_MAC;
        end
      end
      S_OUT0: begin
        if (out_hs_s) begin
          if (beat_q == BTW'(NB-1)) begin
            state_d = S_OUT1;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BTW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_OUT1: begin
        if (out_hs_s) begin
          if (beat_q == BTW'(NB-1)) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BTW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
    if (go_mac_s) begin
      state_d    = S_MAC;
      cur_v_d    = 1'b1;
      cur_i_d    = '0;
      cur_a_d    = '0;
      cur_b_d    = '0;
      key_addr_d = key_addr_of(ksel_d, DW'(0), AW'(0));
    end else begin
      key_addr_d = key_addr_d;
    end
    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    valid_d = (state_d == S_OUT0) || (state_d == S_OUT1);
    poly_d  = (state_d == S_OUT1);
    last_d  = poly_d && (beat_d == BTW'(NB-1));
    busy_d  = (state_d != S_IDLE);
    coeff_d = '0;
    if (valid_d) begin
      for (int t = 0; t < TILE_N; t++)
        coeff_d[t*BIT_WIDTH +: BIT_WIDTH] = poly_d ? acc1_d[AW'(int'(beat_d)*TILE_N + t)]
                                                   : acc0_d[AW'(int'(beat_d)*TILE_N + t)];
    end else begin
      coeff_d = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ksel_q     <= '0;
      beat_q     <= '0;
      cur_v_q    <= 1'b0;
      cur_i_q    <= '0;
      cur_a_q    <= '0;
      cur_b_q    <= '0;
      p_v_q      <= 1'b0;
      p_i_q      <= '0;
      p_a_q      <= '0;
      p_b_q      <= '0;
      key_addr_q <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      poly_q     <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      coeff_q    <= '0;
      for (int k = 0; k < DEGREE_N; k++) begin
        c2_q[k]   <= '0;
        acc0_q[k] <= '0;
        acc1_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ksel_q     <= ksel_d;
      beat_q     <= beat_d;
      cur_v_q    <= cur_v_d;
      cur_i_q    <= cur_i_d;
      cur_a_q    <= cur_a_d;
      cur_b_q    <= cur_b_d;
      p_v_q      <= p_v_d;
      p_i_q      <= p_i_d;
      p_a_q      <= p_a_d;
      p_b_q      <= p_b_d;
      key_addr_q <= key_addr_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      poly_q     <= poly_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      coeff_q    <= coeff_d;
      c2_q       <= c2_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
    end
  end

  assign ready_o    = ready_q;
  assign key_addr_o = key_addr_q;
  assign valid_o    = valid_q;
  assign poly_sel_o = poly_q;
  assign last_o     = last_q;
  assign coeff_o    = coeff_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_relin_stream_engine.sv
// Directed bench for relin_stream_engine with a registered-read key memory model.
module tb_relin_stream_engine;
  localparam int N   = 8;
  localparam int TN  = 2;
  localparam int BW  = 8;
  localparam int NB  = N / TN;
  localparam int KAW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i;
  logic           ready_o;
  logic [TN*BW-1:0] coeff_i;
  logic           key_sel_i;
  logic [KAW-1:0] key_addr_o;
  logic [BW-1:0]  key_rdata0;
  logic [BW-1:0]  key_rdata1;
  logic           valid_o;
  logic           ready_i;
  logic           poly_sel_o;
  logic           last_o;
  logic [TN*BW-1:0] coeff_o;
  logic           busy_o;

  logic [BW-1:0]  kmem0 [64];
  logic [BW-1:0]  kmem1 [64];
  logic [BW-1:0]  vin   [N];
  logic [BW-1:0]  exp0  [N];
  logic [BW-1:0]  exp1  [N];
  logic [3:0]     rdy_pat = 4'b1001;
  int             n_pass = 0;
  int             n_chk  = 0;

  relin_stream_engine dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .coeff_i(coeff_i),
    .key_sel_i(key_sel_i), .key_addr_o(key_addr_o), .key_rdata0_i(key_rdata0),
    .key_rdata1_i(key_rdata1), .valid_o(valid_o), .ready_i(ready_i),
    .poly_sel_o(poly_sel_o), .last_o(last_o), .coeff_o(coeff_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    key_rdata0 <= kmem0[key_addr_o];
    key_rdata1 <= kmem1[key_addr_o];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 64; i++) begin
      kmem0[i] = 8'd0;
      kmem1[i] = 8'd0;
    end
  endtask

  task automatic basic_keys();
    clear_keys();
    for (int i = 0; i < 4; i++) begin
      kmem0[i] = 8'(5 + i);
      kmem1[i] = 8'(1 + i);
    end
  endtask

  // key_sel_i is flipped after the first beat; only the first beat's value may count.
  task automatic send_tile(input logic ksel, output bit ok);
    int guard;
    ok = 1'b1;
    for (int b = 0; b < NB; b++) begin
      guard     = 0;
      valid_i   = 1'b1;
      key_sel_i = (b == 0) ? ksel : ~ksel;
      coeff_i   = {vin[b*TN+1], vin[b*TN]};
      while (ready_o !== 1'b1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (ready_o !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  task automatic run_out(input string name, input bit bp);
    int lat, nb, cyc, eb;
    logic [TN*BW-1:0] tile;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, 32'd258);
    nb  = 0;
    cyc = 0;
    while (nb < 2*NB && cyc < 100) begin
      ready_i = bp ? rdy_pat[cyc % 4] : 1'b1;
      eb = nb % NB;
      if (nb < NB) tile = {exp0[eb*TN+1], exp0[eb*TN]};
      else         tile = {exp1[eb*TN+1], exp1[eb*TN]};
      check($sformatf("%s beat%0d", name, nb), {valid_o, poly_sel_o, last_o, coeff_o},
            {1'b1, (nb >= NB), (nb == 2*NB-1), tile});
      if (valid_o === 1'b1 && ready_i === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    ready_i = 1'b0;
    check({name, " beats"}, nb, 2*NB);
    check({name, " idle"}, {valid_o, ready_o, busy_o, last_o}, 4'b0100);
  endtask

  task automatic do_run(input string name, input logic ksel, input bit bp);
    bit ok;
    send_tile(ksel, ok);
    check({name, " accept"}, 32'(ok), 32'd1);
    run_out(name, bp);
  endtask

  initial begin
    bit ok;
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0; coeff_i = '0; key_sel_i = 1'b0;
    clear_keys();
    repeat (2) @(negedge clk);
    check("reset ctl", {ready_o, valid_o, busy_o, last_o, poly_sel_o}, 5'b00000);
    check("reset coeff", coeff_o, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("ready after reset", {ready_o, busy_o}, 2'b10);

    basic_keys();
    vin  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp0 = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
    exp1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    do_run("basic", 1'b0, 1'b0);

    // x^5 * (5+6x+7x^2+8x^3): only the x^8 term wraps, to -8.
    vin  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
    exp0 = '{8'd89, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd6, 8'd7};
    exp1 = '{8'd93, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    do_run("wrap", 1'b0, 1'b0);

    clear_keys();
    kmem0[0]  = 8'd5;
    kmem0[8]  = 8'd50;
    kmem0[40] = 8'd9;
    kmem1[42] = 8'd11;
    vin  = '{8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp0 = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp1 = '{8'd0, 8'd0, 8'd11, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_run("keysel", 1'b1, 1'b0);

    clear_keys();
    kmem0[0] = 8'd96;
    for (int i = 0; i < 4; i++) kmem1[i] = 8'(1 + i);
    vin  = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp0 = '{8'd94, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp1 = '{8'd3, 8'd6, 8'd9, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0};
    do_run("modred", 1'b0, 1'b0);

    // 85 has every base-4 digit equal to 1: four wrapped -50 terms and four +30 terms.
    clear_keys();
    for (int i = 0; i < 4; i++) begin
      kmem0[i*8+1] = 8'd50;
      kmem1[i*8]   = 8'd30;
    end
    vin  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd85};
    exp0 = '{8'd91, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp1 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd23};
    do_run("alldigits", 1'b0, 1'b0);

    basic_keys();
    vin  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    exp0 = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
    exp1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    do_run("backpressure", 1'b0, 1'b1);

    vin = '{8'd7, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    send_tile(1'b0, ok);
    check("abort accept", 32'(ok), 32'd1);
    repeat (100) @(negedge clk);
    check("mid mac", {busy_o, ready_o, valid_o}, 3'b100);
    rst = 1'b0;
    @(negedge clk);
    check("abort ctl", {valid_o, busy_o, ready_o, last_o, poly_sel_o}, 5'b00000);
    rst = 1'b1;
    vin = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_run("after abort", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
